// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill/flush controller: fetches a missing line from L2 and writes it
// into a round-robin victim way, or sweeps every set clearing all valid bits.
module icache_refill_ctrl #(
   parameter int TAG_WIDTH  = 20,
   parameter int IDX_WIDTH  = 8,
   parameter int LINE_WIDTH = 128,
   parameter int N_WAY      = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           miss_i,
   input  logic [TAG_WIDTH-1:0]           miss_tag_i,
   input  logic [IDX_WIDTH-1:0]           miss_idx_i,
   input  logic                           kill_i,
   input  logic                           flush_i,
   output logic                           l2_req_o,
   output logic [TAG_WIDTH+IDX_WIDTH-1:0] l2_addr_o,
   input  logic                           l2_gnt_i,
   input  logic                           l2_valid_i,
   input  logic [LINE_WIDTH-1:0]          l2_data_i,
   output logic [N_WAY-1:0]               tag_req_o,
   output logic [N_WAY-1:0]               data_req_o,
   output logic                           tag_we_o,
   output logic                           data_we_o,
   output logic                           flush_en_o,
   output logic                           valid_bit_o,
   output logic [LINE_WIDTH-1:0]          cline_o,
   output logic [TAG_WIDTH-1:0]           tag_o,
   output logic [IDX_WIDTH-1:0]           addr_o,
   output logic                           busy_o,
   output logic                           refill_done_o,
   output logic                           flush_done_o
);

   localparam int WAY_BITS = (N_WAY > 1) ? $clog2(N_WAY) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_FLUSH = 3'd4
   } state_t;

   state_t                  state_reg, state_next;
   logic [TAG_WIDTH-1:0]    tag_reg;
   logic [IDX_WIDTH-1:0]    idx_reg;
   logic [LINE_WIDTH-1:0]   line_reg;
   logic [WAY_BITS-1:0]     victim_reg;
   logic [IDX_WIDTH-1:0]    cnt_reg;
   logic                    flush_pend_reg;
   logic                    killed_reg;
   logic                    killed_next;
   logic                    l2_req_reg;
   logic [N_WAY-1:0]        way_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < N_WAY; gi++) begin : g_way_dec
         assign way_onehot[gi] = (victim_reg == WAY_BITS'(gi));
      end
   endgenerate

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; a flush always beats a simultaneous miss
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (flush_pend_reg || flush_i) begin
               state_next = S_FLUSH;
            end else if (miss_i) begin
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (l2_gnt_i) begin
               state_next = S_WAIT;
            end else if (kill_i) begin
               state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            if (l2_valid_i) begin
               state_next = (killed_reg || kill_i) ? S_IDLE : S_WRITE;
            end
         end
         S_WRITE: state_next = S_IDLE;
         S_FLUSH: begin
            if (cnt_reg == '1) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A granted request cannot be withdrawn, so a kill only marks the response for discard
   always_comb begin
      killed_next = 1'b0;
      case (state_reg)
         S_REQ:   killed_next = kill_i && l2_gnt_i;
         S_WAIT:  killed_next = l2_valid_i ? 1'b0 : (killed_reg || kill_i);
         default: killed_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_reg        <= '0;
         idx_reg        <= '0;
         line_reg       <= '0;
         victim_reg     <= '0;
         cnt_reg        <= '0;
         flush_pend_reg <= 1'b0;
         killed_reg     <= 1'b0;
         l2_req_reg     <= 1'b0;
      end else begin
         killed_reg <= killed_next;
         l2_req_reg <= (state_next == S_REQ);

         if (state_reg == S_IDLE && !flush_pend_reg && !flush_i && miss_i) begin
            tag_reg <= miss_tag_i;
            idx_reg <= miss_idx_i;
         end

         if (state_reg == S_WAIT && l2_valid_i) begin
            line_reg <= l2_data_i;
         end

         if (state_reg == S_WRITE) begin
            victim_reg <= victim_reg + WAY_BITS'(1);
         end

         // Pending flush is consumed on the IDLE cycle that launches the sweep
         if (state_reg == S_IDLE) begin
            flush_pend_reg <= 1'b0;
         end else if (state_reg != S_FLUSH && flush_i) begin
            flush_pend_reg <= 1'b1;
         end

         if (state_reg == S_FLUSH) begin
            cnt_reg <= cnt_reg + IDX_WIDTH'(1);
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   // Output logic
   always_comb begin
      tag_req_o     = '0;
      data_req_o    = '0;
      tag_we_o      = 1'b0;
      data_we_o     = 1'b0;
      flush_en_o    = 1'b0;
      valid_bit_o   = 1'b0;
      cline_o       = '0;
      tag_o         = '0;
      addr_o        = '0;
      refill_done_o = 1'b0;
      flush_done_o  = 1'b0;
      case (state_reg)
         S_WRITE: begin
            tag_req_o     = way_onehot;
            data_req_o    = way_onehot;
            tag_we_o      = 1'b1;
            data_we_o     = 1'b1;
            valid_bit_o   = 1'b1;
            cline_o       = line_reg;
            tag_o         = tag_reg;
            addr_o        = idx_reg;
            refill_done_o = 1'b1;
         end
         S_FLUSH: begin
            tag_req_o    = '1;
            tag_we_o     = 1'b1;
            flush_en_o   = 1'b1;
            addr_o       = cnt_reg;
            flush_done_o = (cnt_reg == '1);
         end
         default: ;
      endcase
   end

   assign busy_o    = (state_reg != S_IDLE);
   assign l2_req_o  = l2_req_reg;
   assign l2_addr_o = l2_req_reg ? {tag_reg, idx_reg} : '0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: refills, victim rotation, kill, flush, pending flush, reset.
module tb_icache_refill_ctrl;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          miss_i;
   logic [19:0]   miss_tag_i;
   logic [7:0]    miss_idx_i;
   logic          kill_i;
   logic          flush_i;
   logic          l2_req_o;
   logic [27:0]   l2_addr_o;
   logic          l2_gnt_i;
   logic          l2_valid_i;
   logic [127:0]  l2_data_i;
   logic [3:0]    tag_req_o;
   logic [3:0]    data_req_o;
   logic          tag_we_o;
   logic          data_we_o;
   logic          flush_en_o;
   logic          valid_bit_o;
   logic [127:0]  cline_o;
   logic [19:0]   tag_o;
   logic [7:0]    addr_o;
   logic          busy_o;
   logic          refill_done_o;
   logic          flush_done_o;

   int total = 0;
   int bad   = 0;

   icache_refill_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .miss_i        (miss_i),
      .miss_tag_i    (miss_tag_i),
      .miss_idx_i    (miss_idx_i),
      .kill_i        (kill_i),
      .flush_i       (flush_i),
      .l2_req_o      (l2_req_o),
      .l2_addr_o     (l2_addr_o),
      .l2_gnt_i      (l2_gnt_i),
      .l2_valid_i    (l2_valid_i),
      .l2_data_i     (l2_data_i),
      .tag_req_o     (tag_req_o),
      .data_req_o    (data_req_o),
      .tag_we_o      (tag_we_o),
      .data_we_o     (data_we_o),
      .flush_en_o    (flush_en_o),
      .valid_bit_o   (valid_bit_o),
      .cline_o       (cline_o),
      .tag_o         (tag_o),
      .addr_o        (addr_o),
      .busy_o        (busy_o),
      .refill_done_o (refill_done_o),
      .flush_done_o  (flush_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_refill(input logic [19:0] t, input logic [7:0] ix,
                            input logic [127:0] d, input logic [3:0] way);
      miss_i = 1'b1; miss_tag_i = t; miss_idx_i = ix;
      step();
      miss_i = 1'b0;
      check("req_high", l2_req_o, 1);
      check("l2_addr", l2_addr_o, {t, ix});
      check("req_no_write", tag_we_o, 0);
      l2_gnt_i = 1'b1;
      step();
      l2_gnt_i = 1'b0;
      check("req_drop", l2_req_o, 0);
      check("wait_busy", busy_o, 1);
      l2_valid_i = 1'b1; l2_data_i = d;
      step();
      l2_valid_i = 1'b0; l2_data_i = '0;
      check("wr_tag_req", tag_req_o, way);
      check("wr_data_req", data_req_o, way);
      check("wr_we", {tag_we_o, data_we_o, valid_bit_o, flush_en_o}, 4'b1110);
      check("wr_cline", cline_o, d);
      check("wr_tag", tag_o, t);
      check("wr_addr", addr_o, ix);
      check("wr_done", refill_done_o, 1);
      step();
      check("ret_busy", busy_o, 0);
      check("ret_done", refill_done_o, 0);
      $display("refill tag=%05h idx=%02h way=%b", t, ix, way);
   endtask

   initial begin
      int n;
      int seen;
      rst_i = 1'b1; miss_i = 0; miss_tag_i = 0; miss_idx_i = 0; kill_i = 0;
      flush_i = 0; l2_gnt_i = 0; l2_valid_i = 0; l2_data_i = '0;
      step(); step();
      check("rst_outs", {l2_req_o, tag_we_o, data_we_o, busy_o, refill_done_o, flush_done_o, flush_en_o}, 0);
      check("rst_addr", {l2_addr_o, addr_o, tag_req_o}, 0);
      rst_i = 1'b0;
      step();

      // First refill then rotation through all ways and wrap
      do_refill(20'hABCDE, 8'h12, {16{8'h55}}, 4'b0001);
      do_refill(20'h11111, 8'h01, {4{32'hDEADBEEF}}, 4'b0010);
      do_refill(20'h22222, 8'hFF, {2{64'h0123456789ABCDEF}}, 4'b0100);
      do_refill(20'h33333, 8'h80, {16{8'hA5}}, 4'b1000);
      do_refill(20'h44444, 8'h00, {16{8'h3C}}, 4'b0001);

      // Kill in WAIT, response three cycles later is dropped
      miss_i = 1'b1; miss_tag_i = 20'h55555; miss_idx_i = 8'h33;
      step(); miss_i = 1'b0;
      l2_gnt_i = 1'b1; step(); l2_gnt_i = 1'b0;
      kill_i = 1'b1; step(); kill_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) l2_valid_i = 1'b1;
         seen += refill_done_o + tag_we_o;
         step();
      end
      l2_valid_i = 1'b0;
      seen += refill_done_o + tag_we_o;
      check("kill_no_write", seen, 0);
      check("kill_idle", busy_o, 0);
      $display("kill in WAIT: writes seen=%0d", seen);
      do_refill(20'h66666, 8'h44, {16{8'h77}}, 4'b0010);

      // Full flush sweep from IDLE
      flush_i = 1'b1; step(); flush_i = 1'b0;
      for (int i = 0; i < 256; i++) begin
         check("fl_addr", addr_o, i);
         check("fl_done", flush_done_o, (i == 255));
         check("fl_strb", {tag_req_o, data_req_o}, 8'hF0);
         check("fl_ctl", {tag_we_o, flush_en_o, valid_bit_o, data_we_o}, 4'b1100);
         step();
      end
      check("fl_end_busy", busy_o, 0);
      check("fl_end_done", flush_done_o, 0);
      $display("flush sweep complete");

      // Flush requested during WAIT is served after the refill
      miss_i = 1'b1; miss_tag_i = 20'h77777; miss_idx_i = 8'h99;
      step(); miss_i = 1'b0;
      l2_gnt_i = 1'b1; step(); l2_gnt_i = 1'b0;
      flush_i = 1'b1; l2_valid_i = 1'b1; l2_data_i = {16{8'h12}};
      step(); flush_i = 1'b0; l2_valid_i = 1'b0; l2_data_i = '0;
      check("pend_wr_way", tag_req_o, 4'b0100);
      check("pend_wr_done", refill_done_o, 1);
      check("pend_wr_flen", flush_en_o, 0);
      step();
      check("pend_idle", {busy_o, flush_en_o}, 0);
      step();
      check("pend_fl_start", flush_en_o, 1);
      check("pend_fl_addr", addr_o, 0);
      n = 0;
      while (!flush_done_o && n < 300) begin
         step();
         n++;
      end
      check("pend_fl_done", flush_done_o, 1);
      check("pend_fl_len", n, 255);
      step();
      check("pend_fl_busy", busy_o, 0);
      $display("pending flush served, cycles to done=%0d", n);

      // Miss and flush together: flush wins, then reset mid-sweep
      miss_i = 1'b1; flush_i = 1'b1; miss_tag_i = 20'h88888; miss_idx_i = 8'h01;
      step(); miss_i = 1'b0; flush_i = 1'b0;
      check("mf_flush", flush_en_o, 1);
      check("mf_no_req", l2_req_o, 0);
      for (int i = 0; i < 100; i++) step();
      check("mf_addr100", addr_o, 100);
      #2 rst_i = 1'b1;
      #1;
      check("arst_outs", {l2_req_o, tag_we_o, data_we_o, busy_o, flush_en_o, flush_done_o, refill_done_o}, 0);
      check("arst_vec", {tag_req_o, data_req_o, addr_o}, 0);
      step();
      rst_i = 1'b0;
      step();
      check("arst_no_done", {flush_done_o, busy_o}, 0);
      $display("reset during flush at addr 100");
      do_refill(20'h99999, 8'h05, {16{8'hC3}}, 4'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
